// File: rtl/text_ctrl_pkg.sv
// Shared types and key/scancode constants for the text-entry cursor controller.
package text_ctrl_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef enum logic [2:0] {
        OP_ADV,
        OP_RET,
        OP_NEWLINE,
        OP_TAB,
        OP_LEFT,
        OP_RIGHT,
        OP_UP,
        OP_DOWN
    } step_op_t;

    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_TAB       = 8'h09;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= ASCII_PRINT_MIN) && (code <= ASCII_PRINT_MAX);
    endfunction

endpackage

// File: rtl/text_cursor_step.sv
// Combinational next-cell calculator: owns every wrap and saturate rule for
// the cursor and for the clear-sweep counter.
module text_cursor_step
    import text_ctrl_pkg::*;
#(
    parameter int CHAR_HORZ_CNT = 80,
    parameter int CHAR_VERT_CNT = 25,
    parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
    parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
    parameter int TAB_STOP      = 8
) (
    input  logic [CHAR_HORZ_W-1:0] col,
    input  logic [CHAR_VERT_W-1:0] row,
    input  step_op_t               op,
    output logic [CHAR_HORZ_W-1:0] next_col,
    output logic [CHAR_VERT_W-1:0] next_row
);

    localparam logic [CHAR_HORZ_W-1:0] COL_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
    localparam logic [CHAR_VERT_W-1:0] ROW_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
    localparam logic [CHAR_HORZ_W-1:0] TAB_MASK = CHAR_HORZ_W'(TAB_STOP - 1);
    localparam logic [CHAR_HORZ_W:0]   COL_CNT  = (CHAR_HORZ_W + 1)'(CHAR_HORZ_CNT);

    logic [CHAR_VERT_W-1:0] row_wrap_inc;
    logic [CHAR_HORZ_W:0]   tab_col;

    // 80 and 25 are not powers of two, so wrap is an explicit compare.
    assign row_wrap_inc = (row == ROW_LAST) ? '0 : row + CHAR_VERT_W'(1);
    // One extra bit so a stop at or past the last column is detectable.
    assign tab_col      = {1'b0, col | TAB_MASK} + (CHAR_HORZ_W + 1)'(1);

    always_comb begin
        next_col = col;
        next_row = row;
        case (op)
            OP_ADV: begin
                if (col == COL_LAST) begin
                    next_col = '0;
                    next_row = row_wrap_inc;
                end else begin
                    next_col = col + CHAR_HORZ_W'(1);
                end
            end
            OP_RET: begin
                if (col != '0) begin
                    next_col = col - CHAR_HORZ_W'(1);
                end else if (row != '0) begin
                    next_col = COL_LAST;
                    next_row = row - CHAR_VERT_W'(1);
                end
            end
            OP_NEWLINE: begin
                next_col = '0;
                next_row = row_wrap_inc;
            end
            OP_TAB: begin
                if (tab_col >= COL_CNT) begin
                    next_col = '0;
                    next_row = row_wrap_inc;
                end else begin
                    next_col = tab_col[CHAR_HORZ_W-1:0];
                end
            end
            OP_LEFT:  if (col != '0)      next_col = col - CHAR_HORZ_W'(1);
            OP_RIGHT: if (col != COL_LAST) next_col = col + CHAR_HORZ_W'(1);
            OP_UP:    if (row != '0)      next_row = row - CHAR_VERT_W'(1);
            OP_DOWN:  if (row != ROW_LAST) next_row = row + CHAR_VERT_W'(1);
            default: ;
        endcase
    end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Turns PS/2 ASCII/scancode events into character-cell writes and a cursor
// position; runs a full-screen space sweep after reset or on request.
module text_cursor_ctrl
    import text_ctrl_pkg::*;
#(
    parameter int CHAR_HORZ_CNT = 80,
    parameter int CHAR_VERT_CNT = 25,
    parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
    parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
    parameter int TAB_STOP      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ascii_vld,
    input  logic [7:0]             ascii,
    input  logic                   scancode_vld,
    input  logic [7:0]             scancode,
    input  logic                   clear_req,
    output logic                   char_write_en,
    output logic [CHAR_HORZ_W-1:0] char_hpos,
    output logic [CHAR_VERT_W-1:0] char_vpos,
    output logic [7:0]             char_symbol,
    output logic [CHAR_HORZ_W-1:0] cursor_hpos,
    output logic [CHAR_VERT_W-1:0] cursor_vpos,
    output logic                   cursor_valid,
    output logic                   busy
);

    localparam logic [CHAR_HORZ_W-1:0] COL_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
    localparam logic [CHAR_VERT_W-1:0] ROW_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);

    state_t                 state_reg, state_next;
    logic [CHAR_HORZ_W-1:0] sweep_col_reg, sweep_col_next;
    logic [CHAR_VERT_W-1:0] sweep_row_reg, sweep_row_next;
    logic [CHAR_HORZ_W-1:0] cur_col_reg, cur_col_next;
    logic [CHAR_VERT_W-1:0] cur_row_reg, cur_row_next;
    logic                   wr_en_reg, wr_en_next;
    logic [CHAR_HORZ_W-1:0] wr_col_reg, wr_col_next;
    logic [CHAR_VERT_W-1:0] wr_row_reg, wr_row_next;
    logic [7:0]             wr_sym_reg, wr_sym_next;
    logic                   busy_reg, busy_next;

    step_op_t               step_op;
    logic [CHAR_HORZ_W-1:0] step_col_in, step_col_out;
    logic [CHAR_VERT_W-1:0] step_row_in, step_row_out;

    // One calculator serves both the sweep counter and the cursor.
    assign step_col_in = (state_reg == CLEAR) ? sweep_col_reg : cur_col_reg;
    assign step_row_in = (state_reg == CLEAR) ? sweep_row_reg : cur_row_reg;

    text_cursor_step #(
        .CHAR_HORZ_CNT (CHAR_HORZ_CNT),
        .CHAR_VERT_CNT (CHAR_VERT_CNT),
        .CHAR_HORZ_W   (CHAR_HORZ_W),
        .CHAR_VERT_W   (CHAR_VERT_W),
        .TAB_STOP      (TAB_STOP)
    ) u_step (
        .col      (step_col_in),
        .row      (step_row_in),
        .op       (step_op),
        .next_col (step_col_out),
        .next_row (step_row_out)
    );

    always_comb begin
        state_next     = state_reg;
        sweep_col_next = sweep_col_reg;
        sweep_row_next = sweep_row_reg;
        cur_col_next   = cur_col_reg;
        cur_row_next   = cur_row_reg;
        wr_en_next     = 1'b0;
        wr_col_next    = wr_col_reg;
        wr_row_next    = wr_row_reg;
        wr_sym_next    = wr_sym_reg;
        step_op        = OP_ADV;

        case (state_reg)
            CLEAR: begin
                wr_en_next  = 1'b1;
                wr_col_next = sweep_col_reg;
                wr_row_next = sweep_row_reg;
                wr_sym_next = ASCII_SPACE;
                if (sweep_col_reg == COL_LAST && sweep_row_reg == ROW_LAST) begin
                    state_next     = IDLE;
                    sweep_col_next = '0;
                    sweep_row_next = '0;
                    cur_col_next   = '0;
                    cur_row_next   = '0;
                end else begin
                    sweep_col_next = step_col_out;
                    sweep_row_next = step_row_out;
                end
            end
            default: begin
                // busy_reg is still high for the cycle that shows the last
                // sweep write; events are dropped until it falls.
                if (!busy_reg) begin
                    if (clear_req) begin
                        state_next     = CLEAR;
                        sweep_col_next = '0;
                        sweep_row_next = '0;
                    end else if (ascii_vld) begin
                        if (is_printable(ascii)) begin
                            step_op      = OP_ADV;
                            wr_en_next   = 1'b1;
                            wr_col_next  = cur_col_reg;
                            wr_row_next  = cur_row_reg;
                            wr_sym_next  = ascii;
                            cur_col_next = step_col_out;
                            cur_row_next = step_row_out;
                        end else if (ascii == ASCII_CR || ascii == ASCII_LF) begin
                            step_op      = OP_NEWLINE;
                            cur_col_next = step_col_out;
                            cur_row_next = step_row_out;
                        end else if (ascii == ASCII_TAB) begin
                            step_op      = OP_TAB;
                            cur_col_next = step_col_out;
                            cur_row_next = step_row_out;
                        end else if (ascii == ASCII_BS) begin
                            step_op = OP_RET;
                            if (cur_col_reg != '0 || cur_row_reg != '0) begin
                                wr_en_next   = 1'b1;
                                wr_col_next  = step_col_out;
                                wr_row_next  = step_row_out;
                                wr_sym_next  = ASCII_SPACE;
                                cur_col_next = step_col_out;
                                cur_row_next = step_row_out;
                            end
                        end
                    end else if (scancode_vld) begin
                        if (scancode == SC_LEFT || scancode == SC_RIGHT ||
                            scancode == SC_UP   || scancode == SC_DOWN) begin
                            if (scancode == SC_LEFT)       step_op = OP_LEFT;
                            else if (scancode == SC_RIGHT) step_op = OP_RIGHT;
                            else if (scancode == SC_UP)    step_op = OP_UP;
                            else                           step_op = OP_DOWN;
                            cur_col_next = step_col_out;
                            cur_row_next = step_row_out;
                        end
                    end
                end
            end
        endcase

        busy_next = (state_reg == CLEAR) || (state_next == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CLEAR;
            sweep_col_reg <= '0;
            sweep_row_reg <= '0;
            cur_col_reg   <= '0;
            cur_row_reg   <= '0;
            wr_en_reg     <= 1'b0;
            wr_col_reg    <= '0;
            wr_row_reg    <= '0;
            wr_sym_reg    <= ASCII_SPACE;
            busy_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            sweep_col_reg <= sweep_col_next;
            sweep_row_reg <= sweep_row_next;
            cur_col_reg   <= cur_col_next;
            cur_row_reg   <= cur_row_next;
            wr_en_reg     <= wr_en_next;
            wr_col_reg    <= wr_col_next;
            wr_row_reg    <= wr_row_next;
            wr_sym_reg    <= wr_sym_next;
            busy_reg      <= busy_next;
        end
    end

    assign char_write_en = wr_en_reg;
    assign char_hpos     = wr_col_reg;
    assign char_vpos     = wr_row_reg;
    assign char_symbol   = wr_sym_reg;
    assign cursor_hpos   = cur_col_reg;
    assign cursor_vpos   = cur_row_reg;
    assign busy          = busy_reg;
    assign cursor_valid  = !busy_reg;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: a linear-index screen model predicts
// writes and cursor moves; a forked monitor checks them as the DUT emits them.
module tb_text_cursor_ctrl;

    localparam int W = 80;
    localparam int H = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ascii_vld = 1'b0;
    logic [7:0] ascii = 8'h00;
    logic       scancode_vld = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       clear_req = 1'b0;
    logic       char_write_en;
    logic [6:0] char_hpos;
    logic [4:0] char_vpos;
    logic [7:0] char_symbol;
    logic [6:0] cursor_hpos;
    logic [4:0] cursor_vpos;
    logic       cursor_valid;
    logic       busy;

    text_cursor_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ascii_vld     (ascii_vld),
        .ascii         (ascii),
        .scancode_vld  (scancode_vld),
        .scancode      (scancode),
        .clear_req     (clear_req),
        .char_write_en (char_write_en),
        .char_hpos     (char_hpos),
        .char_vpos     (char_vpos),
        .char_symbol   (char_symbol),
        .cursor_hpos   (cursor_hpos),
        .cursor_vpos   (cursor_vpos),
        .cursor_valid  (cursor_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int h; int v; int s; } wr_t;
    typedef struct { int h; int v; } cur_t;

    wr_t  wq[$];
    cur_t cq[$];
    int   total = 0;
    int   bad = 0;
    int   n_writes = 0;
    int   cx = 0;
    int   cy = 0;
    bit   tag = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic monitor();
        bit   tc;
        wr_t  e;
        cur_t c;
        forever begin
            @(posedge clk);
            tc = tag;
            @(negedge clk);
            if (char_write_en) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_unexpected got=(%0d,%0d,%02h) required=none",
                             char_hpos, char_vpos, char_symbol);
                end else begin
                    e = wq.pop_front();
                    n_writes++;
                    chk("write_h", int'(char_hpos), e.h);
                    chk("write_v", int'(char_vpos), e.v);
                    chk("write_sym", int'(char_symbol), e.s);
                end
            end
            if (tc) begin
                if (cq.size() == 0) begin
                    chk("cursor_queue_nonempty", 0, 1);
                end else begin
                    c = cq.pop_front();
                    chk("cursor_h", int'(cursor_hpos), c.h);
                    chk("cursor_v", int'(cursor_vpos), c.v);
                    chk("cursor_valid", int'(cursor_valid), 1);
                    $display("event -> cursor (%0d,%0d)", cursor_hpos, cursor_vpos);
                end
            end
        end
    endtask

    // Reference model works on the linear cell index row*W+col.
    task automatic model_ascii(input int a);
        int idx, nt;
        if (a >= 32 && a <= 126) begin
            wq.push_back('{cx, cy, a});
            idx = (cy * W + cx + 1) % (W * H);
            cx = idx % W;
            cy = idx / W;
        end else if (a == 13 || a == 10) begin
            cx = 0;
            cy = (cy + 1) % H;
        end else if (a == 8) begin
            idx = cy * W + cx;
            if (idx > 0) begin
                idx--;
                cx = idx % W;
                cy = idx / W;
                wq.push_back('{cx, cy, 32});
            end
        end else if (a == 9) begin
            nt = (cx / 8 + 1) * 8;
            if (nt >= W) begin
                cx = 0;
                cy = (cy + 1) % H;
            end else begin
                cx = nt;
            end
        end
    endtask

    task automatic model_sc(input int s);
        if (s == 'h6B && cx > 0)     cx--;
        if (s == 'h74 && cx < W - 1) cx++;
        if (s == 'h75 && cy > 0)     cy--;
        if (s == 'h72 && cy < H - 1) cy++;
    endtask

    task automatic ev(input bit av, input logic [7:0] a, input bit sv,
                      input logic [7:0] s, input bit clr, input bit track);
        @(posedge clk);
        #1;
        ascii_vld = av;
        ascii = a;
        scancode_vld = sv;
        scancode = s;
        clear_req = clr;
        tag = track;
        if (track) begin
            if (av) model_ascii(int'(a));
            else if (sv) model_sc(int'(s));
            cq.push_back('{cx, cy});
        end
        @(posedge clk);
        #1;
        ascii_vld = 1'b0;
        scancode_vld = 1'b0;
        clear_req = 1'b0;
        tag = 1'b0;
    endtask

    task automatic goto_cell(input int x, input int y);
        while (cy < y) ev(0, 8'h00, 1, 8'h72, 0, 1);
        while (cy > y) ev(0, 8'h00, 1, 8'h75, 0, 1);
        while (cx < x) ev(0, 8'h00, 1, 8'h74, 0, 1);
        while (cx > x) ev(0, 8'h00, 1, 8'h6B, 0, 1);
    endtask

    task automatic push_sweep();
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++)
                wq.push_back('{h, v, 32});
    endtask

    task automatic wait_sweep(input int n0);
        int cyc;
        cyc = 0;
        while (busy && cyc < 2200) begin
            @(negedge clk);
            cyc++;
        end
        chk("sweep_done_in_time", int'(busy), 0);
        chk("sweep_write_count", n_writes - n0, W * H);
        chk("sweep_queue_drained", wq.size(), 0);
        chk("post_sweep_write_en", int'(char_write_en), 0);
        chk("post_sweep_cursor_h", int'(cursor_hpos), 0);
        chk("post_sweep_cursor_v", int'(cursor_vpos), 0);
        chk("post_sweep_valid", int'(cursor_valid), 1);
        $display("sweep finished after %0d cycles", cyc);
        cx = 0;
        cy = 0;
    endtask

    initial begin
        int n0, r;
        logic [7:0] a, s;
        fork
            monitor();
        join_none

        #12;
        chk("rst_write_en", int'(char_write_en), 0);
        chk("rst_hpos", int'(char_hpos), 0);
        chk("rst_vpos", int'(char_vpos), 0);
        chk("rst_symbol", int'(char_symbol), 32);
        chk("rst_busy", int'(busy), 1);
        chk("rst_valid", int'(cursor_valid), 0);
        chk("rst_cursor_h", int'(cursor_hpos), 0);

        @(posedge clk);
        #1;
        push_sweep();
        n0 = n_writes;
        rst_n = 1'b1;
        wait_sweep(n0);

        goto_cell(79, 3);  ev(1, 8'h41, 0, 8'h00, 0, 1);
        goto_cell(79, 24); ev(1, 8'h41, 0, 8'h00, 0, 1);
        ev(1, 8'h08, 0, 8'h00, 0, 1);
        goto_cell(0, 5);   ev(1, 8'h08, 0, 8'h00, 0, 1);
        goto_cell(77, 2);  ev(1, 8'h09, 0, 8'h00, 0, 1);
        goto_cell(3, 2);   ev(1, 8'h09, 0, 8'h00, 0, 1);
        goto_cell(0, 7);   ev(0, 8'h00, 1, 8'h6B, 0, 1);
        goto_cell(10, 24); ev(0, 8'h00, 1, 8'h72, 0, 1);
        goto_cell(5, 5);   ev(1, 8'h42, 1, 8'h74, 0, 1);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: a = 8'($urandom_range(32, 126));
                3:       a = 8'h0D;
                4:       a = 8'h08;
                5:       a = 8'h09;
                default: a = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 4))
                0: s = 8'h6B;
                1: s = 8'h74;
                2: s = 8'h75;
                3: s = 8'h72;
                default: s = 8'($urandom_range(0, 255));
            endcase
            ev(r < 6 || r == 9, a, 1, s, 0, 1);
        end

        ev(1, 8'h42, 0, 8'h00, 1, 0);
        chk("clear_no_char_write", int'(char_write_en), 0);
        chk("clear_busy", int'(busy), 1);
        push_sweep();
        n0 = n_writes;
        for (int i = 0; i < 5; i++) begin
            ev(1, 8'($urandom_range(32, 126)), 1, 8'h74, 0, 0);
            ev(0, 8'h00, 0, 8'h00, 1, 0);
        end
        wait_sweep(n0);

        ev(0, 8'h00, 0, 8'h00, 1, 0);
        push_sweep();
        repeat (500) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_write_en", int'(char_write_en), 0);
        chk("midrst_hpos", int'(char_hpos), 0);
        chk("midrst_vpos", int'(char_vpos), 0);
        chk("midrst_symbol", int'(char_symbol), 32);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_valid", int'(cursor_valid), 0);
        wq.delete();
        repeat (3) @(posedge clk);
        #1;
        push_sweep();
        n0 = n_writes;
        rst_n = 1'b1;
        wait_sweep(n0);

        goto_cell(4, 1);
        ev(1, 8'h5A, 0, 8'h00, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("final_write_queue_empty", wq.size(), 0);
        chk("final_cursor_queue_empty", cq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
